// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: load funct3 encodings and FSM states.
package wb_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// M-stage instruction, data-memory response and register-file write bundle of the write-back stage.
// Handshake: an M-stage instruction is accepted on a rising edge where m_valid=1 and m_stall=0; while m_stall=1 the upstream holds its inputs.
interface wb_stage_if #(parameter int DATA_W = 32);
  logic              m_valid;
  logic              m_rd_wen;
  logic [4:0]        m_rd;
  logic              m_is_load;
  logic [2:0]        m_funct3;
  logic [DATA_W-1:0] m_alu_result;
  logic              dmem_resp_valid;
  logic [DATA_W-1:0] dmem_resp_data;
  logic              m_stall;
  logic              we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              resp_err;

  modport master (
    output m_valid, m_rd_wen, m_rd, m_is_load, m_funct3, m_alu_result,
    output dmem_resp_valid, dmem_resp_data,
    input  m_stall, we, wb_addr, wb_data, resp_err
  );

  modport slave (
    input  m_valid, m_rd_wen, m_rd, m_is_load, m_funct3, m_alu_result,
    input  dmem_resp_valid, dmem_resp_data,
    output m_stall, we, wb_addr, wb_data, resp_err
  );
endinterface

// File: rtl/wb_load_align.sv
// Extracts and extends the addressed byte/half/word of an aligned 32-bit load response.
module wb_load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    half_sel = word[15:0];
    aligned  = word;
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // Halfword selection uses only off[1]; off[0] is deliberately ignored.
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   aligned = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  aligned = {24'd0, byte_sel};
      F3_LH:   aligned = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  aligned = {16'd0, half_sel};
      default: aligned = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-cycle ALU write-back, blocking load wait with aligned write-back,
// and a sticky flag for memory responses that arrive with no load outstanding.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus,
  output wb_state_e  dbg_state_o
);

  wb_state_e         state_q;
  logic              we_q;
  logic [4:0]        wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              resp_err_q;
  logic [4:0]        ld_rd_q;
  logic              ld_wen_q;
  logic [2:0]        ld_funct3_q;
  logic [1:0]        ld_off_q;
  logic [DATA_W-1:0] load_data;

  wb_load_align u_align (
    .word    (bus.dmem_resp_data),
    .funct3  (ld_funct3_q),
    .off     (ld_off_q),
    .aligned (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= '0;
      resp_err_q  <= 1'b0;
      ld_rd_q     <= 5'd0;
      ld_wen_q    <= 1'b0;
      ld_funct3_q <= 3'd0;
      ld_off_q    <= 2'd0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // No load is outstanding, so any response here is spurious and dropped.
          if (bus.dmem_resp_valid) resp_err_q <= 1'b1;
          if (bus.m_valid) begin
            if (bus.m_is_load) begin
              ld_rd_q     <= bus.m_rd;
              ld_wen_q    <= bus.m_rd_wen;
              ld_funct3_q <= bus.m_funct3;
              ld_off_q    <= bus.m_alu_result[1:0];
              state_q     <= ST_WAIT_LOAD;
            end else if (bus.m_rd_wen && (bus.m_rd != 5'd0)) begin
              we_q      <= 1'b1;
              wb_addr_q <= bus.m_rd;
              wb_data_q <= bus.m_alu_result;
            end
          end
        end
        ST_WAIT_LOAD: begin
          if (bus.dmem_resp_valid) begin
            state_q <= ST_IDLE;
            if (ld_wen_q && (ld_rd_q != 5'd0)) begin
              we_q      <= 1'b1;
              wb_addr_q <= ld_rd_q;
              wb_data_q <= load_data;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_stall  = (state_q == ST_WAIT_LOAD);
  assign bus.we       = we_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.resp_err = resp_err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed checks of the write-back stage: reset, ALU write, x0 suppression, load alignment,
// stall timing, spurious responses and reset during an outstanding load.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic      clk;
  logic      reset;
  wb_state_e dbg_state;
  int        checks;
  int        errors;

  wb_stage_if #(.DATA_W(32)) bus ();

  wb_stage #(.DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m_valid         = 1'b0;
    bus.m_rd_wen        = 1'b0;
    bus.m_rd            = 5'd0;
    bus.m_is_load       = 1'b0;
    bus.m_funct3        = 3'd0;
    bus.m_alu_result    = 32'd0;
    bus.dmem_resp_valid = 1'b0;
    bus.dmem_resp_data  = 32'd0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic wen, input logic [31:0] val);
    bus.m_valid      = 1'b1;
    bus.m_is_load    = 1'b0;
    bus.m_rd_wen     = wen;
    bus.m_rd         = rd;
    bus.m_funct3     = 3'd0;
    bus.m_alu_result = val;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr);
    bus.m_valid      = 1'b1;
    bus.m_is_load    = 1'b1;
    bus.m_rd_wen     = 1'b1;
    bus.m_rd         = rd;
    bus.m_funct3     = f3;
    bus.m_alu_result = addr;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    drive_alu(5'd3, 1'b1, 32'hAAAA_5555);
    step();
    step();
    reset = 1'b0;
    clear_inputs();
    step();
    checks++;
    if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.we); end
    checks++;
    if (bus.wb_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.wb_addr); end
    checks++;
    if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.wb_data); end
    checks++;
    if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", bus.resp_err); end
    checks++;
    if (bus.m_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.m_stall); end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
  endtask

  task automatic test_alu_write();
    drive_alu(5'd5, 1'b1, 32'h1234_5678);
    step();
    clear_inputs();
    checks++;
    if (bus.we !== 1'b1) begin errors++; $display("FAIL alu_we: got %b expected 1", bus.we); end
    checks++;
    if (bus.wb_addr !== 5'd5) begin errors++; $display("FAIL alu_addr: got %0d expected 5", bus.wb_addr); end
    checks++;
    if (bus.wb_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_data: got %h expected 12345678", bus.wb_data); end
    step();
    checks++;
    if (bus.we !== 1'b0) begin errors++; $display("FAIL alu_we_drop: got %b expected 0", bus.we); end
    checks++;
    if (bus.wb_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_data_hold: got %h expected 12345678", bus.wb_data); end
    // Valid ALU op with rd_wen=0 must not write.
    drive_alu(5'd6, 1'b0, 32'h0BAD_0BAD);
    step();
    clear_inputs();
    checks++;
    if (bus.we !== 1'b0) begin errors++; $display("FAIL alu_nowen: got %b expected 0", bus.we); end
  endtask

  task automatic test_back_to_back();
    drive_alu(5'd1, 1'b1, 32'h0000_0011);
    step();
    drive_alu(5'd2, 1'b1, 32'h0000_0022);
    checks++;
    if (bus.we !== 1'b1 || bus.wb_addr !== 5'd1 || bus.wb_data !== 32'h11) begin
      errors++; $display("FAIL b2b_first: got we=%b addr=%0d data=%h expected we=1 addr=1 data=11", bus.we, bus.wb_addr, bus.wb_data);
    end
    step();
    clear_inputs();
    checks++;
    if (bus.we !== 1'b1 || bus.wb_addr !== 5'd2 || bus.wb_data !== 32'h22) begin
      errors++; $display("FAIL b2b_second: got we=%b addr=%0d data=%h expected we=1 addr=2 data=22", bus.we, bus.wb_addr, bus.wb_data);
    end
    step();
  endtask

  task automatic test_x0();
    drive_alu(5'd0, 1'b1, 32'h0000_DEAD);
    step();
    clear_inputs();
    checks++;
    if (bus.we !== 1'b0) begin errors++; $display("FAIL x0_alu_we: got %b expected 0", bus.we); end
    drive_load(5'd0, F3_LW, 32'h0000_0100);
    step();
    clear_inputs();
    checks++;
    if (dbg_state !== ST_WAIT_LOAD) begin errors++; $display("FAIL x0_load_state: got %0d expected WAIT_LOAD", dbg_state); end
    checks++;
    if (bus.we !== 1'b0) begin errors++; $display("FAIL x0_load_we_wait: got %b expected 0", bus.we); end
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_resp_data  = 32'h5555_AAAA;
    step();
    clear_inputs();
    checks++;
    if (bus.we !== 1'b0) begin errors++; $display("FAIL x0_load_we: got %b expected 0", bus.we); end
    checks++;
    if (bus.m_stall !== 1'b0) begin errors++; $display("FAIL x0_load_stall: got %b expected 0", bus.m_stall); end
    checks++;
    if (bus.wb_data !== 32'h22) begin errors++; $display("FAIL x0_data_hold: got %h expected 22", bus.wb_data); end
    checks++;
    if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL x0_resp_err: got %b expected 0", bus.resp_err); end
  endtask

  task automatic test_load_align();
    logic [2:0]  f3_t  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b010, 3'b011};
    logic [31:0] adr_t [8] = '{32'h13, 32'h21, 32'h32, 32'h40, 32'h50, 32'h63, 32'h73, 32'h80};
    logic [31:0] exp_t [8] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                               32'h80FF_7F01, 32'hFFFF_80FF, 32'h80FF_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 8; i++) begin
      drive_load(5'd10 + 5'(i), f3_t[i], adr_t[i]);
      step();
      clear_inputs();
      checks++;
      if (bus.m_stall !== 1'b1 || bus.we !== 1'b0) begin
        errors++; $display("FAIL align_wait[%0d]: got stall=%b we=%b expected stall=1 we=0", i, bus.m_stall, bus.we);
      end
      bus.dmem_resp_valid = 1'b1;
      bus.dmem_resp_data  = 32'h80FF_7F01;
      step();
      clear_inputs();
      checks++;
      if (bus.we !== 1'b1 || bus.wb_addr !== 5'd10 + 5'(i) || bus.wb_data !== exp_t[i]) begin
        errors++; $display("FAIL align[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                           i, bus.we, bus.wb_addr, bus.wb_data, 10 + i, exp_t[i]);
      end
    end
  endtask

  task automatic test_stall();
    drive_load(5'd7, F3_LW, 32'h0000_0200);
    step();
    // Upstream has advanced to the next instruction and holds it while stalled.
    drive_alu(5'd8, 1'b1, 32'h0000_0888);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus.m_stall !== 1'b1 || bus.we !== 1'b0) begin
        errors++; $display("FAIL stall_cycle%0d: got stall=%b we=%b expected stall=1 we=0", c, bus.m_stall, bus.we);
      end
      if (c == 3) begin
        bus.dmem_resp_valid = 1'b1;
        bus.dmem_resp_data  = 32'hCAFE_BABE;
      end
      step();
    end
    bus.dmem_resp_valid = 1'b0;
    checks++;
    if (bus.m_stall !== 1'b0 || bus.we !== 1'b1 || bus.wb_addr !== 5'd7 || bus.wb_data !== 32'hCAFE_BABE) begin
      errors++; $display("FAIL stall_load_wb: got stall=%b we=%b addr=%0d data=%h expected stall=0 we=1 addr=7 data=cafebabe",
                         bus.m_stall, bus.we, bus.wb_addr, bus.wb_data);
    end
    step();
    clear_inputs();
    checks++;
    if (bus.we !== 1'b1 || bus.wb_addr !== 5'd8 || bus.wb_data !== 32'h0000_0888) begin
      errors++; $display("FAIL stall_queued_alu: got we=%b addr=%0d data=%h expected we=1 addr=8 data=888", bus.we, bus.wb_addr, bus.wb_data);
    end
    step();
    checks++;
    if (bus.we !== 1'b0) begin errors++; $display("FAIL stall_we_drop: got %b expected 0", bus.we); end
  endtask

  task automatic test_spurious();
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_resp_data  = 32'h1111_1111;
    step();
    clear_inputs();
    checks++;
    if (bus.we !== 1'b0 || dbg_state !== ST_IDLE || bus.wb_addr !== 5'd8) begin
      errors++; $display("FAIL spur_nowrite: got we=%b state=%0d addr=%0d expected we=0 state=IDLE addr=8", bus.we, dbg_state, bus.wb_addr);
    end
    checks++;
    if (bus.resp_err !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b expected 1", bus.resp_err); end
    step();
    step();
    checks++;
    if (bus.resp_err !== 1'b1) begin errors++; $display("FAIL spur_err_hold: got %b expected 1", bus.resp_err); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL spur_err_clear: got %b expected 0", bus.resp_err); end
  endtask

  task automatic test_reset_mid_load();
    drive_load(5'd9, F3_LW, 32'h0000_0300);
    step();
    clear_inputs();
    checks++;
    if (bus.m_stall !== 1'b1) begin errors++; $display("FAIL rml_stall_before: got %b expected 1", bus.m_stall); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.m_stall !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rml_stall_after: got stall=%b state=%0d expected stall=0 state=IDLE", bus.m_stall, dbg_state);
    end
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_resp_data  = 32'h9999_9999;
    step();
    clear_inputs();
    checks++;
    if (bus.we !== 1'b0 || bus.wb_addr !== 5'd0) begin
      errors++; $display("FAIL rml_nowrite: got we=%b addr=%0d expected we=0 addr=0", bus.we, bus.wb_addr);
    end
    checks++;
    if (bus.resp_err !== 1'b1) begin errors++; $display("FAIL rml_resp_err: got %b expected 1", bus.resp_err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_alu_write();
    test_back_to_back();
    test_x0();
    test_load_align();
    test_stall();
    test_spurious();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the datapath and register width; only 32 is supported.
REQ-002 clk  input  1  single clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 m_valid  input  1  M-stage instruction present this cycle.
REQ-005 m_rd_wen  input  1  instruction writes a destination register.
REQ-006 m_rd  input  5  destination register index.
REQ-007 m_is_load  input  1  instruction is a load.
REQ-008 m_funct3  input  3  load width/sign encoding.
REQ-009 m_alu_result  input  DATA_W  ALU result for non-loads; byte address for loads.
REQ-010 dmem_resp_valid  input  1  data-memory read response valid.
REQ-011 dmem_resp_data  input  DATA_W  raw aligned 32-bit memory word.
REQ-012 m_stall  output  1  upstream SHALL hold the M-stage inputs while this is high.
REQ-013 we  output  1  register-file write enable, registered.
REQ-014 wb_addr  output  5  register-file write index, registered.
REQ-015 wb_data  output  DATA_W  register-file write data, registered.
REQ-016 resp_err  output  1  sticky flag for an unexpected memory response.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and WAIT_LOAD; m_stall SHALL equal (state == WAIT_LOAD), decoded combinationally.
REQ-018 In IDLE, an instruction with m_valid=1, m_is_load=0, m_rd_wen=1 and m_rd!=0 SHALL produce we=1, wb_addr=m_rd and wb_data=m_alu_result on the next cycle (1-cycle latency).
REQ-019 Any accepted instruction with m_rd=0 or m_rd_wen=0 SHALL never assert we; x0 writes are suppressed here.
REQ-020 we SHALL be high for exactly one cycle per qualifying instruction; otherwise it is 0, and wb_addr/wb_data hold their last values.
REQ-021 In IDLE, m_valid=1 with m_is_load=1 SHALL capture rd, rd_wen, funct3 and addr[1:0], then move to WAIT_LOAD; we SHALL be 0 the next cycle.
REQ-022 A load SHALL enter WAIT_LOAD even when rd=0, to preserve memory ordering, and SHALL write nothing on completion.
REQ-023 In WAIT_LOAD, m_valid and all other M-stage inputs SHALL be ignored.
REQ-024 In WAIT_LOAD, dmem_resp_valid=1 SHALL return the FSM to IDLE; if rd!=0 and rd_wen=1, the next cycle SHALL show we=1 and wb_data=aligned(dmem_resp_data).
REQ-025 m_stall SHALL remain 1 during the response cycle; the upstream instruction is accepted on the following cycle.
REQ-026 Load alignment, with byte offset off=addr[1:0]:
- LB (000): byte[off], sign-extended.
- LBU (100): byte[off], zero-extended.
- LH (001): half[addr[1]], sign-extended.
- LHU (101): half[addr[1]], zero-extended.
- LW (010): full word.
REQ-027 For LH/LHU, addr[0] SHALL be ignored; for LW, addr[1:0] SHALL be ignored (no misalignment trap).
REQ-028 Undefined funct3 values (011, 110, 111) SHALL be treated as LW.
REQ-029 dmem_resp_valid=1 while in IDLE SHALL be dropped (no write, no state change) and SHALL set resp_err=1 until reset.
REQ-030 Responses never arrive in the same cycle as load acceptance; a response in that cycle SHALL be handled per REQ-029.

Reset
REQ-031 On reset, the block SHALL force state=IDLE, we=0, wb_addr=0, wb_data=0, resp_err=0 and m_stall=0, and SHALL clear the captured load fields.
REQ-032 Reset asserted in WAIT_LOAD SHALL abandon the pending load without any write; a later response SHALL be handled per REQ-029.
REQ-033 Reset SHALL take priority over every simultaneous input event.

Structure
REQ-034 A shared package SHALL hold the load funct3 constants (LB, LH, LW, LBU, LHU) and the FSM state encoding.
REQ-035 Load alignment SHALL be a combinational sub-module named wb_load_align (inputs: word, funct3, off; output: aligned data); everything else is in wb_stage.

Verification
REQ-036 ALU write: m_valid=1, rd=5, m_alu_result=0x1234_5678 -> next cycle we=1, wb_addr=5, wb_data=0x1234_5678; the cycle after that, we=0.
REQ-037 x0 suppression: ALU op with rd=0, then a load with rd=0 and a response -> we stays 0 throughout; the FSM passes through WAIT_LOAD.
REQ-038 Load alignment on word 0x80FF_7F01:
- LB off=3 -> 0xFFFF_FF80.
- LBU off=1 -> 0x0000_007F.
- LH addr=2 -> 0xFFFF_80FF.
- LHU addr=0 -> 0x0000_7F01.
- LW -> 0x80FF_7F01.
REQ-039 Stall: issue a load with rd=7, response after 3 cycles -> m_stall=1 for exactly 3 cycles, including the response cycle; we=1 and wb_addr=7 the cycle after the response; a queued ALU op (rd=8) is written one cycle after that.
REQ-040 Spurious response: dmem_resp_valid=1 in IDLE -> no write, resp_err=1 and held; reset -> resp_err=0.
REQ-041 Reset mid-load: a load with rd=9, reset asserted in WAIT_LOAD, then a response -> no write to x9, m_stall=0 after reset, resp_err=1.
